a_chan_req_fifo: RTL and testbench
==================================

# a_chan_req_fifo

Request buffer on the A channel between the bus master and the bus slave. It accepts 53-bit A-channel beats from the master. It stores them in order in a small circular FIFO and presents them to the slave with a valid/ready handshake. The master therefore keeps issuing while the slave holds `a_ready` low. It also reports occupancy and flags any beat the master drives while the FIFO is full.

## Interface
- `A_WIDTH`, 53: A-channel beat width; payload is opaque to this block.
- `DEPTH`, 4: entry count; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: width of the occupancy count (derived, not overridden).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_a_valid` in 1: master has a beat.
- `in_a_ready` out 1: FIFO can accept a beat this cycle.
- `in_a_channel` in A_WIDTH: beat from master.
- `out_a_valid` out 1: head entry available to slave.
- `out_a_ready` in 1: slave's `a_ready`.
- `out_a_channel` out A_WIDTH: head entry.
- `level` out CNT_W: number of stored entries, 0..DEPTH.
- `overflow` out 1: sticky; a beat was offered while full.

## Operation
- Storage: DEPTH×A_WIDTH array, write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits and wrapping modulo DEPTH; `count` register of CNT_W bits.
- Push = `in_a_valid & in_a_ready`. Entry written at `wp`; `wp` increments.
- Pop = `out_a_valid & out_a_ready`. `rp` increments.
- `count` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_a_ready = ~reset & (count != DEPTH)`. It is combinational from registers only and never depends on `out_a_ready`.
- `out_a_valid = (count != 0)`. `out_a_channel = mem[rp]`. No bypass: a beat pushed into an empty FIFO is never visible in the same cycle.
- `overflow` is set when `in_a_valid & ~in_a_ready & ~reset`. It stays set until reset. The offered beat is dropped, and storage and pointers are unchanged.
- `level = count`.

## Timing
- Reset, sampled at a rising edge, sets `wp=rp=0`, `count=0`, all entries to 0 and `overflow=0`. After that edge: `out_a_valid=0`, `out_a_channel=0`, `level=0`.
- `in_a_ready` reads 0 in any cycle where `reset` is high. It reads 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all stored beats. A push or pop in the reset cycle has no effect.
- Latency: push at edge N makes `out_a_valid=1` from cycle N+1. Throughput is one beat per cycle when the FIFO is neither empty nor full.
- When full (`count==DEPTH`), `in_a_ready=0` even if a pop occurs in the same cycle. The freed slot is usable one cycle later.
- When empty, a push with `out_a_ready=1` is not popped in that cycle.
- Stability: while `out_a_valid=1 & out_a_ready=0`, `out_a_channel` and `out_a_valid` hold.
- When empty, `out_a_channel` shows `mem[rp]`, which is the last written value or 0 after reset. The bench checks it only while valid.
- Pointer wrap: after DEPTH pushes `wp` returns to 0. FIFO order is preserved across wraps.

## Structure
- The shared bus package holds `A_CHANNEL_W=53` and `D_CHANNEL_W=43`. `A_WIDTH` defaults from `A_CHANNEL_W`.
- Flat module with no sub-module. Pointers, count and array stay in one always block plus the combinational ready/valid assigns.

## Test plan
- Reset check: assert `reset` 2 cycles → `level=0`, `out_a_valid=0`, `overflow=0`, `in_a_ready=0` during reset, `in_a_ready=1` the cycle after.
- Pass-through: `out_a_ready=1`, push 0x0_0000_0000_0023 at cycle 0 → `out_a_valid=1` with the same value at cycle 1, `level` 1→0 at cycle 2.
- Fill while slave stalls: `out_a_ready=0`, push 4 beats 1,2,3,4 → `level=4`, `in_a_ready=0`, `out_a_channel=1`. Release ready → outputs 1,2,3,4 on 4 consecutive cycles, then `out_a_valid=0`.
- Simultaneous push/pop: level 2, both handshakes every cycle for 10 cycles → `level` stays 2, order intact across pointer wrap.
- Full plus pop: level 4, `out_a_ready=1` and `in_a_valid=1` → that cycle no push (`in_a_ready=0`), `level=3`. The next cycle the push is accepted, `level=3`.
- Overflow: full, master drives `in_a_valid=1` with value 0x55 → `overflow=1` sticky, 0x55 never appears on `out_a_channel`. Reset clears `overflow`.

Source files
------------

// File: rtl/a_chan_req_fifo_pkg.sv
// Shared bus package: channel widths used by the A/D channel blocks.
package a_chan_req_fifo_pkg;
    localparam int A_CHANNEL_W = 53;
    localparam int D_CHANNEL_W = 43;
endpackage

// File: rtl/a_chan_req_fifo.sv
// A-channel request buffer: circular FIFO between bus master and slave with
// valid/ready handshakes on both sides, occupancy output and sticky overflow.
module a_chan_req_fifo
    import a_chan_req_fifo_pkg::*;
#(
    parameter  int A_WIDTH = A_CHANNEL_W,
    parameter  int DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_a_valid,
    output logic               in_a_ready,
    input  logic [A_WIDTH-1:0] in_a_channel,
    output logic               out_a_valid,
    input  logic               out_a_ready,
    output logic [A_WIDTH-1:0] out_a_channel,
    output logic [CNT_W-1:0]   level,
    output logic               overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [A_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wp_q, wp_d;
    logic [PTR_W-1:0]   rp_q, rp_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               push, pop;

    // Ready looks only at registered occupancy, so a pop on a full cycle frees
    // the slot for the following cycle rather than this one.
    assign in_a_ready    = ~reset & (count_q != CNT_W'(DEPTH));
    assign out_a_valid   = (count_q != '0);
    assign out_a_channel = mem_q[rp_q];
    assign level         = count_q;
    assign overflow      = ovf_q;

    assign push = in_a_valid & in_a_ready;
    assign pop  = out_a_valid & out_a_ready;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q | (in_a_valid & ~in_a_ready & ~reset);
        if (push) wp_d = wp_q + PTR_W'(1);
        if (pop)  rp_d = rp_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) mem_q[wp_q] <= in_a_channel;
        end
    end
endmodule

// File: tb/tb_a_chan_req_fifo.sv
// Bench for a_chan_req_fifo: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference.
module tb_a_chan_req_fifo;
    localparam int AW    = 53;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_a_valid = 1'b0;
    logic          in_a_ready;
    logic [AW-1:0] in_a_channel = '0;
    logic          out_a_valid;
    logic          out_a_ready = 1'b0;
    logic [AW-1:0] out_a_channel;
    logic [CW-1:0] level;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    a_chan_req_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .in_a_valid   (in_a_valid),
        .in_a_ready   (in_a_ready),
        .in_a_channel (in_a_channel),
        .out_a_valid  (out_a_valid),
        .out_a_ready  (out_a_ready),
        .out_a_channel(out_a_channel),
        .level        (level),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FIFO contents as an ordered queue plus the sticky flag.
    logic [AW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (in_a_valid && mq.size() == DEPTH) m_ovf = 1'b1;
            if (out_a_ready && mq.size() > 0) begin
                if (in_a_valid && mq.size() < DEPTH) mq.push_back(in_a_channel);
                void'(mq.pop_front());
            end else if (in_a_valid && mq.size() < DEPTH) begin
                mq.push_back(in_a_channel);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_a_ready", in_a_ready, !reset && mq.size() != DEPTH);
            check("out_a_valid", out_a_valid, mq.size() != 0);
            check("level", level, mq.size());
            check("overflow", overflow, m_ovf);
            if (mq.size() != 0) check("out_a_channel", out_a_channel, mq[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        reset = 1'b1;
        step();
        step();
        check("rst_level", level, 0);
        check("rst_valid", out_a_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_chan", out_a_channel, 0);
        check("rst_in_ready", in_a_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_a_ready, 1);

        // Pass-through
        out_a_ready = 1'b1; in_a_valid = 1'b1; in_a_channel = 53'h23;
        step();
        in_a_valid = 1'b0;
        check("pt_valid", out_a_valid, 1);
        check("pt_chan", out_a_channel, 53'h23);
        check("pt_level1", level, 1);
        step();
        check("pt_level0", level, 0);
        check("pt_empty", out_a_valid, 0);

        // Fill while slave stalls, then drain
        out_a_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_a_valid = 1'b1; in_a_channel = AW'(i);
            step();
        end
        in_a_valid = 1'b0;
        check("fill_level", level, 4);
        check("fill_in_ready", in_a_ready, 0);
        check("fill_head", out_a_channel, 1);
        out_a_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", out_a_valid, 1);
            check("drain_chan", out_a_channel, i);
            step();
        end
        check("drain_empty", out_a_valid, 0);

        // Simultaneous push/pop at level 2 across pointer wrap
        out_a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_a_valid = 1'b1; in_a_channel = AW'(12'h100 + i);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            in_a_valid = 1'b1; in_a_channel = AW'(12'h102 + k); out_a_ready = 1'b1;
            check("pp_level", level, 2);
            check("pp_chan", out_a_channel, 12'h100 + k);
            step();
        end
        in_a_valid = 1'b0;
        step();
        step();
        check("pp_drained", level, 0);

        // Full plus pop: the freed slot is usable one cycle later
        out_a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a_valid = 1'b1; in_a_channel = AW'(12'h200 + i);
            step();
        end
        out_a_ready = 1'b1; in_a_valid = 1'b1; in_a_channel = 53'h204;
        #1;
        check("fp_in_ready", in_a_ready, 0);
        step();
        check("fp_level_a", level, 3);
        check("fp_in_ready2", in_a_ready, 1);
        step();
        in_a_valid = 1'b0;
        check("fp_level_b", level, 3);
        check("fp_head", out_a_channel, 53'h202);
        step(); step(); step();
        check("fp_empty", level, 0);

        // Overflow: offered beat dropped, flag sticky until reset
        out_a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a_valid = 1'b1; in_a_channel = AW'(12'h300 + i);
            step();
        end
        in_a_channel = 53'h55;
        step();
        in_a_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 4);
        step();
        check("ovf_sticky", overflow, 1);
        out_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", out_a_channel, 12'h300 + i);
            step();
        end
        check("ovf_drained", out_a_valid, 0);
        check("ovf_still", overflow, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Randomized traffic with varying slave backpressure and rare resets
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            in_a_valid   = ($urandom_range(0, 3) != 0);
            in_a_channel = {$urandom(), $urandom()};
            if ((c / 250) % 2 == 0) out_a_ready = ($urandom_range(0, 3) == 0);
            else                    out_a_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; in_a_valid = 1'b0; out_a_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
